// File: rtl/grid_cursor_draw_if.sv
// VGA timing + colour bundle passed between stages of the rgb chain.
// The master drives the bundle and the slave consumes it.
interface grid_cursor_draw_if;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [11:0] rgb;

  modport master (
    output hcount, hsync, hblnk, vcount, vsync, vblnk, rgb
  );

  modport slave (
    input hcount, hsync, hblnk, vcount, vsync, vblnk, rgb
  );
endinterface

// File: rtl/grid_cursor_draw.sv
// Draws a blinking cell-outline highlight over the player and enemy boards.
// Cell selections are captured once per frame; every output lags its input by 2 clk.
module grid_cursor_draw #(
  parameter int          PLAYER_X     = 100,
  parameter int          ENEMY_X      = 538,
  parameter int          GRID_Y       = 200,
  parameter int          CELL         = 32,
  parameter int          CELLS        = 12,
  parameter int          BORDER       = 2,
  parameter logic [11:0] PLAYER_COLOR = 12'hFF0,
  parameter logic [11:0] ENEMY_COLOR  = 12'hF00,
  parameter int          BLINK_FRAMES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  grid_cursor_draw_if.slave     vga_in,
  grid_cursor_draw_if.master    vga_out,
  input  logic [7:0]            player_cor,
  input  logic                  player_sel,
  input  logic [7:0]            enemy_cor,
  input  logic                  enemy_sel
);

  localparam int CELL_SH = $clog2(CELL);
  localparam int CNT_W   = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;

  typedef struct packed {
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_t;

  // ---------------------------------------------------------------------------
  // Frame latch: selections are sampled on the vblank rising edge only.
  // ---------------------------------------------------------------------------
  logic       vblnk_prev;
  logic       frame_latch;
  logic [7:0] player_cor_q;
  logic [7:0] enemy_cor_q;
  logic       player_sel_q;
  logic       enemy_sel_q;

  assign frame_latch = vga_in.vblnk & ~vblnk_prev;

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous here; every register in this block clears on the clock edge.
    if (rst) begin
      vblnk_prev   <= 1'b0;
      player_cor_q <= 8'd0;
      enemy_cor_q  <= 8'd0;
      player_sel_q <= 1'b0;
      enemy_sel_q  <= 1'b0;
    end else begin
      vblnk_prev <= vga_in.vblnk;
      if (frame_latch) begin
        player_cor_q <= player_cor;
        enemy_cor_q  <= enemy_cor;
        player_sel_q <= player_sel;
        enemy_sel_q  <= enemy_sel;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Blink: the phase shown in a frame is the phase held before that frame's
  // latch, so a fresh reset gives BLINK_FRAMES visible frames first.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] frame_cnt;
  logic             phase;
  logic             phase_shown;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt   <= '0;
      phase       <= 1'b1;
      phase_shown <= 1'b1;
    end else if (frame_latch && (BLINK_FRAMES != 0)) begin
      phase_shown <= phase;
      if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        phase     <= ~phase;
      end else begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Cell geometry
  // ---------------------------------------------------------------------------
  // Returns {inside span, within BORDER of either end of the span} for one axis.
  function automatic logic [1:0] axis_hit(input logic [10:0] pos, input logic [10:0] origin);
    logic [11:0] p;
    logic [11:0] lo;
    logic [11:0] hi;
    logic [1:0]  res;
    p      = {1'b0, pos};
    lo     = {1'b0, origin};
    hi     = lo + 12'(CELL - 1);
    res[1] = (p >= lo) && (p <= hi);
    res[0] = (p < lo + 12'(BORDER)) || (p > hi - 12'(BORDER));
    return res;
  endfunction

  function automatic logic outline_hit(
    input logic [10:0] hcount,
    input logic [10:0] vcount,
    input logic [10:0] x_base,
    input logic [7:0]  cor
  );
    logic [3:0]  col;
    logic [3:0]  row;
    logic [10:0] x0;
    logic [10:0] y0;
    logic [1:0]  hx;
    logic [1:0]  hy;
    logic        valid;
    col   = cor[7:4];
    row   = cor[3:0];
    x0    = x_base + (11'(col) << CELL_SH);
    y0    = 11'(GRID_Y) + (11'(row) << CELL_SH);
    valid = (5'(col) < 5'(CELLS)) && (5'(row) < 5'(CELLS));
    hx    = axis_hit(hcount, x0);
    hy    = axis_hit(vcount, y0);
    return valid && hx[1] && hy[1] && (hx[0] || hy[0]);
  endfunction

  logic player_hit;
  logic enemy_hit;

  assign player_hit = outline_hit(vga_in.hcount, vga_in.vcount, 11'(PLAYER_X), player_cor_q);
  assign enemy_hit  = outline_hit(vga_in.hcount, vga_in.vcount, 11'(ENEMY_X),  enemy_cor_q);

  // ---------------------------------------------------------------------------
  // Stage 1: timing, colour and hit flags
  // ---------------------------------------------------------------------------
  vga_t s1;
  logic s1_player_hit;
  logic s1_enemy_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1            <= '0;
      s1_player_hit <= 1'b0;
      s1_enemy_hit  <= 1'b0;
    end else begin
      s1.hcount     <= vga_in.hcount;
      s1.hsync      <= vga_in.hsync;
      s1.hblnk      <= vga_in.hblnk;
      s1.vcount     <= vga_in.vcount;
      s1.vsync      <= vga_in.vsync;
      s1.vblnk      <= vga_in.vblnk;
      s1.rgb        <= vga_in.rgb;
      s1_player_hit <= player_hit;
      s1_enemy_hit  <= enemy_hit;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: colour mux; blanking always passes the upstream colour through.
  // ---------------------------------------------------------------------------
  logic [11:0] rgb_mux;
  vga_t        s2;

  always_comb begin
    // NOTE: default first so no path leaves rgb_mux unassigned (no latch).
    rgb_mux = s1.rgb;
    if (s1.hblnk || s1.vblnk) begin
      rgb_mux = s1.rgb;
    end else if (s1_player_hit && player_sel_q && phase_shown) begin
      rgb_mux = PLAYER_COLOR;
    end else if (s1_enemy_hit && enemy_sel_q && phase_shown) begin
      rgb_mux = ENEMY_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2 <= '0;
    end else begin
      s2     <= s1;
      s2.rgb <= rgb_mux;
    end
  end

  assign vga_out.hcount = s2.hcount;
  assign vga_out.hsync  = s2.hsync;
  assign vga_out.hblnk  = s2.hblnk;
  assign vga_out.vcount = s2.vcount;
  assign vga_out.vsync  = s2.vsync;
  assign vga_out.vblnk  = s2.vblnk;
  assign vga_out.rgb    = s2.rgb;

endmodule

// File: doc/grid_cursor_draw.md
Name: grid_cursor_draw

Overview:
- VGA pipeline stage that draws a cell-outline highlight on the player board and the enemy board.
- It is the inverse mapping of mouse-to-cell decoding: it takes a selected cell coordinate and turns it back into a pixel rectangle.
- It sits in the timing/rgb chain after the board renderers and before the VGA output register.
- Cell selections are latched once per frame; the outline can optionally blink.

Parameters:
- PLAYER_X, 100, left pixel x of player grid
- ENEMY_X, 538, left pixel x of enemy grid
- GRID_Y, 200, top pixel y of both grids
- CELL, 32, cell pitch in pixels (power of two)
- CELLS, 12, cells per row/column; valid col/row 0..CELLS-1
- BORDER, 2, outline thickness in pixels (1..CELL/2)
- PLAYER_COLOR, 12'hFF0, player-board highlight rgb
- ENEMY_COLOR, 12'hF00, enemy-board highlight rgb
- BLINK_FRAMES, 16, frames per blink half-period; 0 = steady on

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset, synchronous, active-high
- hcount_in  in  11  horizontal pixel count
- hsync_in  in  1  hsync
- hblnk_in  in  1  hblank
- vcount_in  in  11  vertical line count
- vsync_in  in  1  vsync
- vblnk_in  in  1  vblank
- rgb_in  in  12  upstream pixel colour
- player_cor  in  8  player cell, [7:4]=col, [3:0]=row
- player_sel  in  1  player cell selection valid
- enemy_cor  in  8  enemy cell, [7:4]=col, [3:0]=row
- enemy_sel  in  1  enemy cell selection valid
- hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out  out  11/1/1/11/1/1  timing delayed 2 clk
- rgb_out  out  12  pixel colour, delayed 2 clk

Behaviour:
- Reset: all outputs 0; latched cor = 0, latched sel = 0; blink phase = 1 (visible); frame counter = 0. A reset mid-frame drops any highlight until the next frame latch.
- Frame latch:
  - Triggered on a vblnk_in rising edge (vblnk_in=1 while the registered previous value = 0).
  - Copies player_cor/player_sel and enemy_cor/enemy_sel into shadow registers.
  - Input changes between latches have no visible effect.
- Blink:
  - Each frame latch increments the frame counter.
  - When the counter reaches BLINK_FRAMES-1, it wraps to 0 and the blink phase toggles.
  - With BLINK_FRAMES=0, the phase is held at 1.
- Cell rectangle:
  - x0 = BOARD_X + col*CELL, y0 = GRID_Y + row*CELL, computed as shift-and-add in 11 bits.
  - Covers x0..x0+CELL-1, y0..y0+CELL-1.
- Outline pixel:
  - The pixel is inside the rectangle and is within BORDER of any edge: hcount<x0+BORDER, or hcount>x0+CELL-1-BORDER, or the same conditions for vcount.
- Invalid cell: col>=CELLS or row>=CELLS → that board draws nothing; the latch still occurs.
- Pipeline:
  - Stage 1 registers timing, rgb, and the per-board outline hit flags.
  - Stage 2 registers the output mux.
  - Latency is exactly 2 clk for every signal, and timing outputs are bit-exact delayed copies.
- Mux priority:
  - blank (hblnk or vblnk) → rgb passes through unchanged;
  - else player hit & player_sel latched & phase → PLAYER_COLOR;
  - else enemy hit & enemy_sel latched & phase → ENEMY_COLOR;
  - else rgb passes through.
  - The boards do not overlap; the priority only matters for misconfigured parameters.
- Both selections valid → both outlines drawn in the same frame.

Test Plan:
- Player (col 2, row 3), BORDER=2, BLINK_FRAMES=0, latched. Rectangle is x0=164, y0=296:
  - pixel (164,300) → 12'hFF0;
  - pixel (195,296) → 12'hFF0;
  - pixel (180,310) → rgb_in;
  - pixel (167,300) → rgb_in.
  - All colour outputs appear 2 clk after the input pixel.
- Enemy (col 0, row 0), both selections valid: pixel (538,200) → 12'hF00; player outline still drawn in the same frame; pixel (570,200) → rgb_in (outside cell).
- Change player_cor from 8'h23 to 8'h55 mid-frame → the current frame still outlines (2,3); the next frame after the vblnk rise outlines (5,5) at x0=260, y0=360.
- Invalid coordinate: player_cor=8'hC0 with player_sel=1 → no highlight anywhere; rgb_out equals rgb_in delayed 2 clk, and timing outputs are likewise delayed 2 clk.
- Blink with BLINK_FRAMES=2 → outline visible frames 1–2, hidden frames 3–4, visible frames 5–6 (frames counted from the first latch after reset).
- Assert rst for 1 clk mid-frame with a selection latched:
  - next clk: all outputs 0;
  - afterwards: no outline until the following vblnk rise;
  - blink phase restarts visible.
